// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning 16-beat bit-reversed FFT frames into natural-order output.
module fft_reorder #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  stall_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [3:0]            out_index,
    output logic                  out_last,
    output logic                  overflow
);
    logic [DATA_WIDTH-1:0] mem_r [32];
    logic [DATA_WIDTH-1:0] mem_i [32];
    logic [1:0] full, fill_mask, rel_mask;
    logic [3:0] wcnt, rcnt, waddr;
    logic       wbank, rbank, accept, hs, rel;

    always_comb begin
        waddr = {wcnt[0], wcnt[1], wcnt[2], wcnt[3]};
        accept = in_valid && !full[wbank];
        out_valid = full[rbank];
        hs = out_valid && out_ready;
        rel = hs && rcnt == 4'd15;
        fill_mask = {1'b0, accept && wcnt == 4'd15} << wbank;
        rel_mask = {1'b0, rel} << rbank;
        // a bank being released this cycle is free again for the upstream next cycle
        stall_out = (full[wbank] && !(rel && rbank == wbank))
                 || (wcnt == 4'd15 && full[!wbank] && !(rel && rbank != wbank));
        out_r = out_valid ? mem_r[{rbank, rcnt}] : '0;
        out_i = out_valid ? mem_i[{rbank, rcnt}] : '0;
        out_index = out_valid ? rcnt : 4'd0;
        out_last = out_valid && rcnt == 4'd15;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_r[{wbank, waddr}] <= in_r;
            mem_i[{wbank, waddr}] <= in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
            wcnt <= 4'd0;
            rcnt <= 4'd0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            overflow <= 1'b0;
        end else begin
            full <= (full & ~rel_mask) | fill_mask;
            if (accept) wcnt <= wcnt + 4'd1;
            if (accept && wcnt == 4'd15) wbank <= !wbank;
            if (hs) rcnt <= rcnt + 4'd1;
            if (rel) rbank <= !rbank;
            if (in_valid && full[wbank]) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed frames with a queue scoreboard checked by an independent output monitor.
module tb_fft_reorder;
    localparam int W = 12;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_r = '0, in_i = '0;
    logic stall_out, out_valid, out_last, overflow;
    logic [W-1:0] out_r, out_i;
    logic [3:0] out_index;

    int checks = 0, failures = 0, n_hs = 0, n0;
    bit saw_stall = 0, have_prev = 0, prev_valid, prev_ready;
    logic [28:0] exp_q[$];
    logic [28:0] prev_act, act, e;
    int seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_reorder #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .stall_out(stall_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_index(out_index), .out_last(out_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        act = {out_last, out_index, out_r, out_i};
        if (rst) have_prev = 0;
        else begin
            if (stall_out) saw_stall = 1;
            if (out_valid && have_prev && prev_valid && !prev_ready) chk("hold", act, prev_act);
            if (!out_valid) chk("idle_zero", act, 0);
            if (out_valid && out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out actual=%0h expected=none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", act, e);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_act = act;
            have_prev = 1;
        end
    end

    task automatic push_frame(input int base);
        for (int j = 0; j < 16; j++)
            exp_q.push_back({j == 15, 4'(j), 12'(base + seq[j]), 12'(12'h800 + base + seq[j])});
    endtask

    task automatic send_beat(input int v);
        in_valid = 1'b1;
        in_r = 12'(v);
        in_i = 12'(12'h800 + v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base);
        push_frame(base);
        for (int k = 0; k < 16; k++) send_beat(base + k);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic frame_latency(input int base);
        out_ready = 1'b1;
        push_frame(base);
        for (int k = 0; k < 15; k++) send_beat(base + k);
        in_valid = 1'b1;
        in_r = 12'(base + 15);
        in_i = 12'(12'h800 + base + 15);
        chk("valid_before_16th", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("valid_after_16th", out_valid, 1);
        chk("first_index", out_index, 0);
        wait_drain();
        chk("valid_after_drain", out_valid, 0);
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_outputs", {out_r, out_i, out_index, out_last}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        saw_stall = 0;
        frame_latency(0);
        chk("single_no_stall", saw_stall, 0);

        saw_stall = 0;
        n0 = n_hs;
        send_frame(128);
        send_frame(144);
        send_frame(160);
        chk("stream_mid_count", n_hs - n0, 32);
        repeat (16) @(posedge clk);
        #1;
        chk("stream_count", n_hs - n0, 48);
        chk("stream_end_valid", out_valid, 0);
        chk("stream_no_stall", saw_stall, 0);

        out_ready = 1'b0;
        send_frame(32);
        push_frame(48);
        for (int k = 0; k < 16; k++) begin
            if (k == 14) chk("stall_wcnt14", stall_out, 0);
            if (k == 15) chk("stall_wcnt15", stall_out, 1);
            send_beat(48 + k);
        end
        chk("overflow_before_drop", overflow, 0);
        send_beat(255);
        chk("overflow_after_drop", overflow, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_held", stall_out, 1);
        out_ready = 1'b1;
        chk("stall_before_drain", stall_out, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("stall_16th_hs", stall_out, 0);
        chk("index_16th_hs", out_index, 15);
        wait_drain();
        chk("overflow_sticky", overflow, 1);

        out_ready = 1'b0;
        send_frame(64);
        n0 = n_hs;
        for (int c = 0; c < 32; c++) begin
            out_ready = (c % 2 == 0);
            @(posedge clk); #1;
        end
        chk("throttle_count", n_hs - n0, 16);
        chk("throttle_queue", exp_q.size(), 0);
        chk("throttle_end_valid", out_valid, 0);

        out_ready = 1'b1;
        send_frame(96);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_index", out_index, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_stall", stall_out, 0);
        chk("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        frame_latency(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
